// File: rtl/uart_responder.sv
// UART responder: serializes OUT bytes onto uart_tx as 8N1 and buffers bytes
// received on uart_rx in a FIFO that answers IN requests oldest-first.
module uart_responder #(
    parameter int CLK_PER_BIT   = 868,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_in_data,
    input  logic       uart_in_valid,
    output logic       uart_in_ready,
    input  logic       uart_out_valid,
    output logic [7:0] uart_out_data,
    output logic       uart_out_ready,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       tx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [PW:0]   DEPTH     = (PW + 1)'(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // ---------------- TX: holding register + shifter ----------------
    state_e        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_full_q, hold_full_d;
    logic          in_ready_q, in_ready_d;
    logic          tx_q, tx_d;
    logic          tx_load;

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        in_ready_d  = 1'b0;
        tx_d        = tx_q;
        tx_load     = 1'b0;

        if (uart_in_valid && !in_ready_q && !hold_full_q) begin
            hold_data_d = uart_in_data;
            hold_full_d = 1'b1;
            in_ready_d  = 1'b1;
        end

        case (tx_state_q)
            S_IDLE: tx_load = hold_full_q;
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        tx_d     = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    // A waiting byte starts straight after the stop bit, no idle gap.
                    tx_load    = hold_full_q;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
        endcase

        if (tx_load) begin
            tx_shift_d  = hold_data_q;
            hold_full_d = 1'b0;
            tx_cnt_d    = '0;
            tx_state_d  = S_START;
            tx_d        = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            in_ready_q  <= in_ready_d;
            tx_q        <= tx_d;
        end
    end

    // ---------------- RX: synchronizer + deserializer ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    state_e        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          push, pop, fifo_full, fifo_empty;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        push        = 1'b0;

        case (rx_state_q)
            // Arming on a falling edge means a low line after a framing error is ignored until it rises.
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q)               frame_err_d = 1'b1;
                    else if (!fifo_full || pop) push        = 1'b1;
                    else                        overrun_d   = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s1_q     <= uart_rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- RX FIFO + IN handshake ----------------
    logic [7:0]    mem_q [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          out_ready_q;
    logic [7:0]    out_data_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH);
    assign pop        = uart_out_valid && !out_ready_q && !fifo_empty;

    // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_ready_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_ready_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                out_data_q <= mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign uart_tx        = tx_q;
    assign uart_in_ready  = in_ready_q;
    assign uart_out_ready = out_ready_q;
    assign uart_out_data  = out_data_q;
    assign tx_busy        = (tx_state_q != S_IDLE) || hold_full_q;
    assign rx_overrun     = overrun_q;
    assign rx_frame_err   = frame_err_q;
endmodule

// File: tb/tb_uart_responder.sv
// Bench for uart_responder: random OUT/IN traffic checked against a queue model
// of the serial frames, the RX FIFO and the sticky flags.
module tb_uart_responder;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_in_data;
    logic       uart_in_valid;
    logic       uart_in_ready;
    logic       uart_out_valid;
    logic [7:0] uart_out_data;
    logic       uart_out_ready;
    logic       uart_tx;
    logic       uart_rx;
    logic       tx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_model[$];
    logic       exp_overrun;
    logic       exp_frame_err;
    logic [7:0] last_out;

    uart_responder #(.CLK_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .uart_in_data   (uart_in_data),
        .uart_in_valid  (uart_in_valid),
        .uart_in_ready  (uart_in_ready),
        .uart_out_valid (uart_out_valid),
        .uart_out_data  (uart_out_data),
        .uart_out_ready (uart_out_ready),
        .uart_tx        (uart_tx),
        .uart_rx        (uart_rx),
        .tx_busy        (tx_busy),
        .rx_overrun     (rx_overrun),
        .rx_frame_err   (rx_frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line level per clock: each frame is start 0, data LSB first, stop 1.
    function automatic logic [95:0] tx_wave(input logic [7:0] a, input logic [7:0] b, input bit two);
        logic [95:0] w;
        logic [9:0]  fr;
        int          n;
        w = '0;
        n = 0;
        for (int f = 0; f < (two ? 2 : 1); f++) begin
            fr = {1'b1, (f == 0) ? a : b, 1'b0};
            for (int k = 0; k < 10; k++)
                for (int c = 0; c < CPB; c++) begin
                    w[n] = fr[k];
                    n++;
                end
        end
        return w;
    endfunction

    task automatic tx_frames(input logic [7:0] a, input logic [7:0] b, input bit two);
        logic [95:0] got;
        int          n;
        got = '0;
        n   = two ? 80 : 40;
        @(negedge clk);
        uart_in_data  = a;
        uart_in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_a", uart_in_ready, 1'b1);
        uart_in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got[i] = uart_tx;
            if (two && i == 0) begin
                uart_in_data  = b;
                uart_in_valid = 1'b1;
            end
            if (two && i == 1) begin
                check("in_ready_b", uart_in_ready, 1'b1);
                uart_in_valid = 1'b0;
            end
            if (i == 2) check("in_ready_pulse", uart_in_ready, 1'b0);
            if (i == 5) check("tx_busy_run", tx_busy, 1'b1);
        end
        check("tx_wave", got, tx_wave(a, b, two));
        @(negedge clk);
        check("tx_busy_idle", tx_busy, 1'b0);
    endtask

    // Drives one frame starting at the current negedge and updates the model.
    task automatic drive_rx(input logic [7:0] d, input logic stop, output int early);
        logic [9:0] fr;
        fr    = {stop, d, 1'b0};
        early = 0;
        for (int k = 0; k < 10; k++) begin
            uart_rx = fr[k];
            repeat (CPB) begin
                @(negedge clk);
                if (uart_out_ready) early++;
            end
        end
        uart_rx = 1'b1;
        if (!stop)                          exp_frame_err = 1'b1;
        else if (rx_model.size() < DEPTH)  rx_model.push_back(d);
        else                                exp_overrun   = 1'b1;
    endtask

    task automatic read_in(input string tag, input int max_wait, output int waited);
        logic [7:0] exp;
        bit         seen;
        seen = 1'b0;
        @(negedge clk);
        uart_out_valid = 1'b1;
        waited = 0;
        while (!seen && waited < max_wait) begin
            @(negedge clk);
            waited++;
            if (uart_out_ready) seen = 1'b1;
        end
        uart_out_valid = 1'b0;
        check({tag, "_seen"}, seen, 1'b1);
        exp = '0;
        if (rx_model.size() > 0) exp = rx_model.pop_front();
        check({tag, "_data"}, uart_out_data, exp);
        last_out = exp;
        @(negedge clk);
        check({tag, "_pulse"}, uart_out_ready, 1'b0);
    endtask

    task automatic expect_empty(input string tag);
        int hits;
        hits = 0;
        uart_out_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (uart_out_ready) hits++;
        end
        uart_out_valid = 1'b0;
        check(tag, hits, 0);
    endtask

    initial begin
        int         early;
        int         w;
        bit         seen;
        logic [7:0] r;

        uart_in_data   = '0;
        uart_in_valid  = 1'b0;
        uart_out_valid = 1'b0;
        uart_rx        = 1'b1;
        exp_overrun    = 1'b0;
        exp_frame_err  = 1'b0;
        last_out       = '0;
        reset          = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_in_ready", uart_in_ready, 1'b0);
        check("rst_out_ready", uart_out_ready, 1'b0);
        check("rst_out_data", uart_out_data, 8'h00);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_overrun", rx_overrun, 1'b0);
        check("rst_frame_err", rx_frame_err, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Transmit: fixed pattern, random singles, back-to-back pairs.
        tx_frames(8'hA5, 8'h00, 1'b0);
        repeat (2) tx_frames(8'($urandom), 8'h00, 1'b0);
        tx_frames(8'h01, 8'h02, 1'b1);
        tx_frames(8'($urandom), 8'($urandom), 1'b1);

        // Receive one byte, then read it back.
        @(negedge clk);
        drive_rx(8'h3C, 1'b1, early);
        repeat (2) @(negedge clk);
        read_in("rx3c", 10, w);
        check("rx3c_latency", w, 1);
        expect_empty("rx3c_empty");
        repeat (3) @(negedge clk);
        check("out_data_hold", uart_out_data, last_out);

        // Request pending on an empty FIFO, answered once the byte arrives.
        @(negedge clk);
        uart_out_valid = 1'b1;
        drive_rx(8'h7E, 1'b1, early);
        check("pend_early", early, 0);
        seen = 1'b0;
        w    = 0;
        while (!seen && w < 20) begin
            @(negedge clk);
            w++;
            if (uart_out_ready) seen = 1'b1;
        end
        uart_out_valid = 1'b0;
        check("pend_seen", seen, 1'b1);
        r = rx_model.pop_front();
        check("pend_data", uart_out_data, r);
        @(negedge clk);

        // Random bytes with random idle gaps, then drain in order.
        for (int i = 0; i < 6; i++) begin
            drive_rx(8'($urandom), 1'b1, early);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        while (rx_model.size() > 0) read_in("rnd", 10, w);

        // One-cycle low glitch: rejected silently.
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        expect_empty("glitch_empty");
        check("glitch_frame_err", rx_frame_err, 1'b0);
        check("glitch_overrun", rx_overrun, 1'b0);

        // Low stop bit: byte dropped, sticky frame error, receiver re-arms.
        @(negedge clk);
        drive_rx(8'h55, 1'b0, early);
        repeat (3) @(negedge clk);
        check("frame_err", rx_frame_err, exp_frame_err);
        expect_empty("frame_err_empty");
        drive_rx(8'h99, 1'b1, early);
        read_in("rearm", 10, w);

        // Overflow: 17 bytes into 16 entries, then read all survivors.
        check("pre_overrun", rx_overrun, 1'b0);
        @(negedge clk);
        for (int b = 0; b < 17; b++) drive_rx(8'(b), 1'b1, early);
        repeat (3) @(negedge clk);
        check("overrun", rx_overrun, exp_overrun);
        for (int i = 0; i < DEPTH; i++) read_in("ovf_read", 10, w);
        expect_empty("ovf_empty");
        check("frame_err_sticky", rx_frame_err, 1'b1);

        // Reset in the middle of a frame.
        @(negedge clk);
        uart_in_data  = 8'h00;
        uart_in_valid = 1'b1;
        @(negedge clk);
        uart_in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_tx", uart_tx, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_tx", uart_tx, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_overrun", rx_overrun, 1'b0);
        check("midrst_frame_err", rx_frame_err, 1'b0);
        check("midrst_out_data", uart_out_data, 8'h00);
        check("midrst_out_ready", uart_out_ready, 1'b0);
        rx_model.delete();
        exp_overrun   = 1'b0;
        exp_frame_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tx_frames(8'($urandom), 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_responder.md
Name: uart_responder

Overview:
- Responder end of the core's UART byte handshakes; sits between the misc exec element and the board's serial pins.
- Accepts OUT bytes on the uart_in_* channel and serializes them onto uart_tx as 8N1.
- Deserializes uart_rx into an RX FIFO and answers IN requests on the uart_out_* channel with the oldest received byte.

Parameters:
CLK_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); minimum 4.
RX_FIFO_DEPTH, 16, RX FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  asynchronous, active-high reset.
uart_in_data  input  8  byte to transmit, valid while uart_in_valid is high.
uart_in_valid  input  1  core requests transmission of uart_in_data.
uart_in_ready  output  1  one-cycle pulse: byte accepted.
uart_out_valid  input  1  core requests one received byte.
uart_out_data  output  8  received byte, meaningful in the cycle uart_out_ready is high.
uart_out_ready  output  1  one-cycle pulse: uart_out_data delivered.
uart_tx  output  1  serial output line, idle high.
uart_rx  input  1  serial input line, asynchronous to clk.
tx_busy  output  1  holding register full or shifter active.
rx_overrun  output  1  sticky: a byte was dropped because the FIFO was full.
rx_frame_err  output  1  sticky: a byte had a low stop bit.

Behaviour:
- Reset, asynchronous: uart_tx=1; uart_in_ready=0; uart_out_ready=0; uart_out_data=0; tx_busy=0; both sticky flags=0.
- Reset also empties the FIFO and returns both FSMs to IDLE. A frame in progress is abandoned; the line returns high immediately.
- OUT handshake:
  - On a posedge where uart_in_valid=1, uart_in_ready=0 and the holding register is empty: latch uart_in_data into the holding register and drive uart_in_ready=1 for exactly one cycle.
  - Otherwise uart_in_ready=0. The core drops valid on the edge where it samples ready; the !uart_in_ready guard prevents double acceptance.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if the holding register is full, move it to the shifter, free the holding register, go to START. This occurs the cycle after acceptance, so a second byte can be accepted while the first shifts.
  - START drives 0; DATA drives bits 0..7, LSB first; STOP drives 1. Each state or bit lasts exactly CLK_PER_BIT cycles.
  - After STOP, go to IDLE. A full holding register starts the next frame with no extra idle bit time.
  - tx_busy = (state != IDLE) | holding full.
- RX path:
  - uart_rx passes through a 2-flop synchronizer, then the RX FSM: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on the synchronized line goes to START.
  - START: after CLK_PER_BIT/2 cycles resample. If high (glitch), return to IDLE with no flag. If low, go to DATA.
  - DATA: sample every CLK_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLK_PER_BIT cycles. If 1 and FIFO not full, push the byte. If 1 and FIFO full, drop the byte and set rx_overrun. If 0, drop the byte, set rx_frame_err, and wait in IDLE until the line is high before re-arming.
- IN handshake:
  - On a posedge where uart_out_valid=1, uart_out_ready=0 and the FIFO is non-empty: uart_out_data <= FIFO head, pop, uart_out_ready=1 for exactly one cycle.
  - If the FIFO is empty, the request waits with ready=0 indefinitely and is answered the cycle after the first push lands.
  - uart_out_data holds its value until the next delivery.
- FIFO pointers wrap modulo RX_FIFO_DEPTH, with a separate count of width clog2(depth)+1.
- Push and pop on the same edge when full: both take effect, count unchanged, no overrun.
- Push and pop on the same edge when empty: the pop is not granted that cycle; the byte is delivered one cycle later.
- Sticky flags clear only on reset.

Test Plan:
- CLK_PER_BIT=4. Raise uart_in_valid with data 0xA5 -> uart_in_ready pulses exactly 1 cycle after valid is seen. uart_tx then shows 0,1,0,1,0,0,1,0,1,1, each level 4 cycles wide. tx_busy is low afterwards.
- Send OUT 0x01 then immediately 0x02 -> second ready pulses while the first frame shifts. Frames are back-to-back with no idle gap; 0x02 bits follow the 0x01 stop bit.
- Drive 0x3C on uart_rx, then request IN -> uart_out_ready pulses one cycle after valid with uart_out_data=0x3C. The FIFO is empty afterwards.
- Request IN with FIFO empty, then drive 0x7E on uart_rx -> ready stays 0 until the byte is pushed, then pulses with 0x7E.
- Drive 17 bytes 0x00..0x10 with depth 16 and no reads -> rx_overrun=1. 16 IN reads return 0x00..0x0F in order.
- Drive a frame with stop bit 0 -> rx_frame_err=1, no byte pushed. Also: 1-cycle low glitch -> nothing pushed, no flag. Also: assert reset mid-TX-frame -> uart_tx=1 immediately and all flags 0.
